div_reconstruct: RTL and testbench

DIV_RECONSTRUCT -- requirements
Module: div_reconstruct

---
 rtl/div_pkg.sv | 12 +
 rtl/div_reconstruct_reg16.sv | 25 ++
 rtl/div_reconstruct.sv | 122 ++++++++++++
 tb/tb_div_reconstruct.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared divider parameters and control state encoding
package div_pkg;

    localparam int DIV_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_reconstruct_reg16.sv
// rtl/div_reconstruct_reg16.sv - enabled operand register with synchronous clear
module reg16 #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] data_q;

    // Capture on enable; reset clears the stored operand
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
        end else if (en_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/div_reconstruct.sv
// rtl/div_reconstruct.sv - rebuilds N = Q*D + R with a serial shift-add multiplier
module div_reconstruct
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   quotient,
    input  logic [WIDTH-1:0]   divisor,
    input  logic [WIDTH-1:0]   remainder,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] dividend,
    output logic               rem_ok,
    output logic               fits
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    div_state_e         state_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_d;
    logic [2*WIDTH-1:0] addend;
    logic [CW-1:0]      cnt_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic               accept;
    logic [WIDTH-1:0]   q_q;
    logic [WIDTH-1:0]   d_q;
    logic [WIDTH-1:0]   r_q;

    // Operands are only captured on the accepting edge, so later port changes cannot leak in
    assign accept = (state_q == IDLE) && in_valid;

    reg16 #(.W(WIDTH)) u_q_reg (
        .clk   (clk),
        .reset (reset),
        .en_i  (accept),
        .d_i   (quotient),
        .q_o   (q_q)
    );

    reg16 #(.W(WIDTH)) u_d_reg (
        .clk   (clk),
        .reset (reset),
        .en_i  (accept),
        .d_i   (divisor),
        .q_o   (d_q)
    );

    // R is kept separately because the accumulator absorbs it as the starting value
    reg16 #(.W(WIDTH)) u_r_reg (
        .clk   (clk),
        .reset (reset),
        .en_i  (accept),
        .d_i   (remainder),
        .q_o   (r_q)
    );

    // One partial product per cycle, LSB of Q first, full-width add so no carry is lost
    always_comb begin
        addend = '0;
        acc_d  = acc_q;
        addend = {{WIDTH{1'b0}}, d_q} << cnt_q;
        if (q_q[cnt_q]) begin
            acc_d = acc_q + addend;
        end
    end

    // Control FSM with registered handshake outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        acc_q      <= {{WIDTH{1'b0}}, remainder};
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= MUL;
                    end
                end
                MUL: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign dividend  = acc_q;
    // Flags are qualified by out_valid so they read 0 outside a presented result
    assign rem_ok    = out_valid_q && (r_q < d_q);
    assign fits      = out_valid_q && (acc_q[2*WIDTH-1:WIDTH] == '0);

endmodule

// File: tb/tb_div_reconstruct.sv
// tb/tb_div_reconstruct.sv - randomized self-checking bench for div_reconstruct
module tb_div_reconstruct;

    localparam int W = 16;

    logic           clk = 1'b0;
    logic           reset;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   quotient;
    logic [W-1:0]   divisor;
    logic [W-1:0]   remainder;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] dividend;
    logic           rem_ok;
    logic           fits;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    div_reconstruct #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .quotient  (quotient),
        .divisor   (divisor),
        .remainder (remainder),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dividend  (dividend),
        .rem_ok    (rem_ok),
        .fits      (fits)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] rand_op();
        case ($urandom_range(0, 3))
            0:       return '0;
            1:       return '1;
            default: return W'($urandom);
        endcase
    endfunction

    // Reference: plain arithmetic on the operand triple
    function automatic logic [63:0] ref_n(input logic [W-1:0] q, d, r);
        return 64'(q) * 64'(d) + 64'(r);
    endfunction

    task automatic run_op(input string tag, input logic [W-1:0] q, d, r, input int stall);
        logic [63:0]    exp_n;
        logic [2*W-1:0] held;
        int             n;
        exp_n = ref_n(q, d, r);
        check({tag, "/in_ready_idle"}, 64'(in_ready), 64'd1);
        quotient  = q;
        divisor   = d;
        remainder = r;
        in_valid  = 1'b1;
        tick();
        n = 1;
        quotient  = W'($urandom);
        divisor   = W'($urandom);
        remainder = W'($urandom);
        out_ready = 1'b1;
        tick();
        n++;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        check({tag, "/latency"}, 64'(n), 64'(W + 1));
        check({tag, "/dividend"}, 64'(dividend), exp_n);
        check({tag, "/rem_ok"}, 64'(rem_ok), 64'(r < d));
        check({tag, "/fits"}, 64'(fits), 64'(exp_n < 64'(1 << W)));
        check({tag, "/in_ready_done"}, 64'(in_ready), 64'd0);
        held = dividend;
        for (int i = 0; i < stall; i++) begin
            in_valid  = 1'b1;
            quotient  = W'($urandom);
            divisor   = W'($urandom);
            remainder = W'($urandom);
            tick();
            in_valid  = 1'b0;
            check({tag, "/stall_dividend"}, 64'(dividend), 64'(held));
            check({tag, "/stall_valid"}, 64'(out_valid), 64'd1);
            check({tag, "/stall_in_ready"}, 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "/release_valid"}, 64'(out_valid), 64'd0);
        check({tag, "/release_in_ready"}, 64'(in_ready), 64'd1);
    endtask

    logic [63:0] exp_q[$];
    logic [63:0] rok_q[$];
    logic [63:0] e;
    int          last_t;
    int          results;
    logic [W-1:0] q, d, r;

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        quotient  = '0;
        divisor   = '0;
        remainder = '0;
        tick();
        tick();
        check("rst/in_ready", 64'(in_ready), 64'd1);
        check("rst/out_valid", 64'(out_valid), 64'd0);
        check("rst/dividend", 64'(dividend), 64'd0);
        check("rst/rem_ok", 64'(rem_ok), 64'd0);
        check("rst/fits", 64'(fits), 64'd0);
        reset = 1'b0;
        tick();

        run_op("small", 16'h0003, 16'h0007, 16'h0002, 0);
        run_op("max", 16'hFFFF, 16'hFFFF, 16'hFFFE, 0);
        run_op("dzero", 16'h1234, 16'h0000, 16'h0005, 1);
        run_op("stall", 16'h0010, 16'h0100, 16'h0001, 5);

        // Reset in the 8th MUL cycle, with in_valid and out_ready also high
        quotient  = 16'h00FF;
        divisor   = 16'h00FF;
        remainder = 16'h0003;
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        reset     = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("midrst/in_ready", 64'(in_ready), 64'd1);
        check("midrst/out_valid", 64'(out_valid), 64'd0);
        check("midrst/dividend", 64'(dividend), 64'd0);
        run_op("after_rst", 16'd2, 16'd3, 16'd1, 0);

        for (int k = 0; k < 12; k++) begin
            run_op($sformatf("rand%0d", k), rand_op(), rand_op(), rand_op(), int'($urandom_range(0, 2)));
        end

        // Streaming with both handshakes held high
        in_valid  = 1'b1;
        out_ready = 1'b1;
        last_t    = -1;
        results   = 0;
        for (int cyc = 0; cyc < 400 && results < 8; cyc++) begin
            if (in_ready) begin
                q = rand_op();
                d = rand_op();
                r = rand_op();
                quotient  = q;
                divisor   = d;
                remainder = r;
                exp_q.push_back(ref_n(q, d, r));
                rok_q.push_back(64'(r < d));
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("b2b/unexpected_result", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("b2b/dividend", 64'(dividend), e);
                    check("b2b/rem_ok", 64'(rem_ok), rok_q.pop_front());
                end
                if (last_t >= 0) begin
                    check("b2b/interval", 64'(cyc - last_t), 64'(W + 2));
                end
                last_t = cyc;
                results++;
            end
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("b2b/result_count", 64'(results), 64'd8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
